stack_cpu_controller: RTL and testbench

//  Multicycle Moore FSM sequencing the 8-bit stack-machine datapath (PC, memory, IR/MDR, stack, A/B/Z, ALU).

---
 rtl/stack_cpu_controller_if.sv | 35 +++
 rtl/stack_cpu_controller.sv | 177 +++++++++++++++++
 tb/tb_stack_cpu_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_cpu_controller_if.sv
// Control bundle between the stack-machine sequencer and its datapath.
// master = sequencer (drives strobes), slave = datapath (drives opcode from IR[7:5]).
interface stack_cpu_controller_if;
    logic [2:0] opcode;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSrc;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       MtoS;
    logic       ldA;
    logic       ldB;
    logic       srcA;
    logic       srcB;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] ALUOp;
    logic       instrDone;
    logic       fault;

    modport master (
        input  opcode,
        output pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
               ldA, ldB, srcA, srcB, push, pop, tos, ALUOp, instrDone, fault
    );

    modport slave (
        output opcode,
        input  pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
               ldA, ldB, srcA, srcB, push, pop, tos, ALUOp, instrDone, fault
    );
endinterface

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore sequencer for the 8-bit stack machine; strobes decode from state only.
// Optional stack-depth guard (CTRL_STACK_GUARD_EN) traps push-on-full / pop-on-empty into a sticky TRAP.
module stack_cpu_controller #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    stack_cpu_controller_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_POPA, S_POPB, S_EXEC2, S_EXEC1, S_PUSHR,
        S_MEMRD, S_PUSHM, S_POPST, S_MEMWR, S_JMP, S_TOSZ, S_JZ
`ifdef CTRL_STACK_GUARD_EN
        , S_TRAP
`endif
    } state_t;

    if (2**DEPTH_W <= STACK_DEPTH) begin : g_depth_w_check
        $error("DEPTH_W too narrow to hold STACK_DEPTH");
    end

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic       push_s;
    logic       pop_s;

`ifdef CTRL_STACK_GUARD_EN
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] depth_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) depth <= '0;
        else      depth <= depth_nxt;
    end
`endif

    // Opcode is held from DECODE so later states stay a pure function of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_nxt       = state;
        push_s          = 1'b0;
        pop_s           = 1'b0;
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.pcSrc       = 1'b0;
        bus.IorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MtoS        = 1'b0;
        bus.ldA         = 1'b0;
        bus.ldB         = 1'b0;
        bus.srcA        = 1'b0;
        bus.srcB        = 1'b0;
        bus.tos         = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.instrDone   = 1'b0;
        bus.fault       = 1'b0;
`ifdef CTRL_STACK_GUARD_EN
        depth_nxt       = depth;
`endif
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                bus.memRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.srcA    = 1'b1;
                bus.srcB    = 1'b1;
                bus.pcWrite = 1'b1;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    3'b100:  state_nxt = S_MEMRD;
                    3'b101:  state_nxt = S_POPST;
                    3'b110:  state_nxt = S_JMP;
                    3'b111:  state_nxt = S_TOSZ;
                    default: state_nxt = S_POPA;
                endcase
            end
            S_POPA: begin
                pop_s     = 1'b1;
                bus.ldA   = 1'b1;
                state_nxt = (op_q == 3'b011) ? S_EXEC1 : S_POPB;
            end
            S_POPB: begin
                pop_s     = 1'b1;
                bus.ldB   = 1'b1;
                state_nxt = S_EXEC2;
            end
            S_EXEC2: begin
                bus.ALUOp = op_q[1:0];
                state_nxt = S_PUSHR;
            end
            S_EXEC1: begin
                bus.ALUOp = 2'b11;
                state_nxt = S_PUSHR;
            end
            S_PUSHR: begin
                push_s        = 1'b1;
                bus.instrDone = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMRD: begin
                bus.IorD    = 1'b1;
                bus.memRead = 1'b1;
                state_nxt   = S_PUSHM;
            end
            S_PUSHM: begin
                push_s        = 1'b1;
                bus.MtoS      = 1'b1;
                bus.instrDone = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_POPST: begin
                pop_s     = 1'b1;
                bus.ldA   = 1'b1;
                state_nxt = S_MEMWR;
            end
            S_MEMWR: begin
                bus.IorD      = 1'b1;
                bus.memWrite  = 1'b1;
                bus.instrDone = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_JMP: begin
                bus.pcSrc     = 1'b1;
                bus.pcWrite   = 1'b1;
                bus.instrDone = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_TOSZ: begin
                bus.tos   = 1'b1;
                state_nxt = S_JZ;
            end
            S_JZ: begin
                bus.pcSrc       = 1'b1;
                bus.pcWriteCond = 1'b1;
                bus.instrDone   = 1'b1;
                state_nxt       = S_FETCH;
            end
`ifdef CTRL_STACK_GUARD_EN
            S_TRAP: begin
                bus.fault = 1'b1;
                state_nxt = S_TRAP;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        bus.push = push_s;
        bus.pop  = pop_s;
`ifdef CTRL_STACK_GUARD_EN
        // Judge against the depth the target state will actually see, so POPA->POPB
        // on a single-entry stack is caught before the second pop.
        depth_nxt = depth + DEPTH_W'(push_s) - DEPTH_W'(pop_s);
        if (((state_nxt == S_POPA) || (state_nxt == S_POPB) || (state_nxt == S_POPST)) &&
            (depth_nxt == '0))
            state_nxt = S_TRAP;
        if (((state_nxt == S_PUSHR) || (state_nxt == S_PUSHM)) &&
            (depth_nxt == DEPTH_W'(STACK_DEPTH)))
            state_nxt = S_TRAP;
`endif
    end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench: small datapath driven by the controller's strobes, checked against an ISA-level model
// (stack queue, memory array, PC) plus the per-opcode cycle counts.
module tb_stack_cpu_controller;
`ifdef CTRL_STACK_GUARD_EN
    localparam int SD   = 2;
    localparam int MAXD = 2;
`else
    localparam int SD   = 16;
    localparam int MAXD = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_cpu_controller_if bus ();
    stack_cpu_controller #(.STACK_DEPTH(SD), .DEPTH_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ---------------- datapath ----------------
    logic [7:0] mem [32];
    logic [7:0] stk [32];
    logic [4:0] pc, sp;
    logic [7:0] ir, a_r, b_r, z_r, alureg, mdr, alu_y, ain, bin;
    logic [7:0] next_instr;
    logic [18:0] outs;

    assign bus.opcode = ir[7:5];
    assign outs = {bus.pcWrite, bus.pcWriteCond, bus.pcSrc, bus.IorD, bus.memRead, bus.memWrite,
                   bus.IRWrite, bus.MtoS, bus.ldA, bus.ldB, bus.srcA, bus.srcB, bus.push,
                   bus.pop, bus.tos, bus.ALUOp, bus.instrDone, bus.fault};

    always_comb begin
        ain = bus.srcA ? {3'b000, pc} : a_r;
        bin = bus.srcB ? 8'd1 : b_r;
        case (bus.ALUOp)
            2'b00:   alu_y = ain + bin;
            2'b01:   alu_y = ain - bin;
            2'b10:   alu_y = ain & bin;
            default: alu_y = ~ain;
        endcase
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0; sp <= '0; ir <= '0; a_r <= '0; b_r <= '0; z_r <= '0;
            alureg <= '0; mdr <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
        end else begin
            alureg <= alu_y;
            if (bus.memRead && bus.IorD) mdr <= mem[ir[4:0]];
            if (bus.IRWrite) ir <= next_instr;
            if (bus.memWrite) mem[ir[4:0]] <= a_r;
            if (bus.pcWrite || (bus.pcWriteCond && z_r == 8'd0))
                pc <= bus.pcSrc ? ir[4:0] : alu_y[4:0];
            if (bus.ldA) a_r <= stk[sp - 5'd1];
            if (bus.ldB) b_r <= stk[sp - 5'd1];
            if (bus.tos) z_r <= stk[sp - 5'd1];
            if (bus.pop) sp <= sp - 5'd1;
            if (bus.push) begin
                stk[sp] <= bus.MtoS ? mdr : alureg;
                sp      <= sp + 5'd1;
            end
        end
    end

    // ---------------- ISA reference model ----------------
    logic [7:0] m_mem [32];
    logic [7:0] m_stk [$];
    int         m_pc;

    int ncmp, nfail;
    int last_fetch_pc, pre_cycles, saw_ldb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'(i);
    endtask

    function automatic int cpi(input logic [2:0] op);
        case (op)
            3'd3:       return 5;
            3'd4, 3'd5: return 4;
            3'd6:       return 3;
            3'd7:       return 4;
            default:    return 6;
        endcase
    endfunction

    task automatic model_exec(input logic [7:0] ins);
        logic [7:0] x, y, r;
        m_pc = (m_pc + 1) % 32;
        case (ins[7:5])
            3'd0, 3'd1, 3'd2: begin
                x = m_stk.pop_back();
                y = m_stk.pop_back();
                r = (ins[7:5] == 3'd0) ? x + y : (ins[7:5] == 3'd1) ? x - y : x & y;
                m_stk.push_back(r);
            end
            3'd3: begin x = m_stk.pop_back(); m_stk.push_back(~x); end
            3'd4: m_stk.push_back(m_mem[ins[4:0]]);
            3'd5: m_mem[ins[4:0]] = m_stk.pop_back();
            3'd6: m_pc = ins[4:0];
            default: if (m_stk[$] == 8'd0) m_pc = ins[4:0];
        endcase
    endtask

    // Runs one instruction from wherever the controller is; returns after the done-cycle edge.
    task automatic run_instr(input logic [7:0] ins);
        bit started = 0, done = 0;
        int cyc = 0;
        next_instr = ins;
        pre_cycles = 0;
        saw_ldb    = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            check("push_pop_excl", 32'(bus.push & bus.pop), 0);
            check("rd_wr_excl", 32'(bus.memRead & bus.memWrite), 0);
            check("fault_clear", 32'(bus.fault), 0);
            if (!started && bus.IRWrite) begin
                started = 1;
                last_fetch_pc = int'(pc);
                check("fetch_pc", 32'(pc), 32'(m_pc));
            end
            if (started) cyc++; else pre_cycles++;
            if (bus.ldB) saw_ldb = 1;
            if (bus.instrDone) done = 1;
        end
        check("instr_done", 32'(done), 1);
        check("cpi", 32'(cyc), 32'(cpi(ins[7:5])));
        model_exec(ins);
        @(posedge clk); #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("depth", 32'(sp), 32'(m_stk.size()));
        if (m_stk.size() > 0) check("top", 32'(stk[sp - 5'd1]), 32'(m_stk[$]));
        if (ins[7:5] == 3'd5) check("mem_wr", 32'(mem[ins[4:0]]), 32'(m_mem[ins[4:0]]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outs", 32'(outs), 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("idle_outs", 32'(outs), 0);
    endtask

`ifdef CTRL_STACK_GUARD_EN
    task automatic run_trap(input logic [7:0] ins);
        next_instr = ins;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("trap_no_push", 32'(bus.push), 0);
            check("trap_no_pop", 32'(bus.pop), 0);
        end
        check("trap_fault", 32'(bus.fault), 1);
        check("trap_depth", 32'(sp), 32'(m_stk.size()));
    endtask
`endif

    initial begin
        ncmp = 0; nfail = 0;
        rst = 1'b0;
        next_instr = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs), 0);
        rst = 1'b1;
        #1;
        check("idle_outs", 32'(outs), 0);

        // Reset arriving mid-EXEC2
        run_instr(8'h85);
        check("first_fetch_pc", 32'(last_fetch_pc), 0);
        check("idle_to_fetch", 32'(pre_cycles), 0);
        run_instr(8'h83);
        next_instr = 8'h20;
        repeat (4) @(negedge clk);
        check("popb_ldb", 32'(bus.ldB), 1);
        @(negedge clk);
        check("exec2_aluop", 32'(bus.ALUOp), 1);
        rst = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("idle_outs", 32'(outs), 0);

        // PUSH 5, PUSH 3, ADD, POP 0x1F
        run_instr(8'h85);
        check("fetch_after_reset", 32'(last_fetch_pc), 0);
        run_instr(8'h83);
        run_instr(8'h00);
        run_instr(8'hBF);
        check("sum_to_1f", 32'(mem[31]), 8);

        // NOT
        run_instr(8'h8F);
        run_instr(8'h60);
        check("not_top", 32'(stk[sp - 5'd1]), 32'h0F0);
        check("not_no_ldb", 32'(saw_ldb), 0);
        run_instr(8'hB0);

        // JZ taken / not taken
        run_instr(8'h80);
        run_instr(8'hEA);
        check("jz_taken_pc", 32'(pc), 32'h0A);
        check("jz_keeps_depth", 32'(sp), 1);
        run_instr(8'hB1);
        run_instr(8'h87);
        run_instr(8'hE3);
        check("jz_fall_pc", 32'(pc), 32'((last_fetch_pc + 1) % 32));
        run_instr(8'hB2);

        // JMP 0x1E then wrap
        run_instr(8'hDE);
        run_instr(8'h81);
        check("seq_fetch_1e", 32'(last_fetch_pc), 32'h1E);
        run_instr(8'hB3);
        check("seq_fetch_1f", 32'(last_fetch_pc), 32'h1F);
        run_instr(8'hC4);
        check("seq_fetch_00", 32'(last_fetch_pc), 0);

        // Random legal programs
        for (int n = 0; n < 80; n++) begin
            logic [2:0] op;
            int d;
            d = m_stk.size();
            do begin
                op = 3'($urandom_range(0, 7));
            end while ((op <= 3'd2 && d < 2) || ((op == 3'd3 || op == 3'd5 || op == 3'd7) && d < 1) ||
                       (op == 3'd4 && d >= MAXD));
            run_instr({op, 5'($urandom_range(0, 31))});
        end

`ifdef CTRL_STACK_GUARD_EN
        do_reset();
        run_instr(8'h85);
        run_instr(8'h83);
        run_trap(8'h85);
        do_reset();
        run_trap(8'hA0);
`else
        do_reset();
        run_instr(8'h8F);
        check("after_reset_depth", 32'(sp), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
